// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbiter/mux with a registered valid/ready output stage.
// Optional RR_MUX_GRANT_HOLD_EN keeps priority on a granted channel for bursts.
module rr_arb_mux #(
    parameter  int W    = 32,
    parameter  int NCH  = 4,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SELW-1:0]  out_sel,
    input  logic             out_ready
);

    localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_sel_q, out_sel_d;

`ifdef RR_MUX_GRANT_HOLD_EN
    logic            hold_q, hold_d;
`endif

    logic [NCH-1:0]  grant;
    logic [SELW-1:0] win;
    logic            any_grant;
    logic            load;

    // Explicit wrap so non-power-of-two channel counts rotate correctly.
    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] i);
        return (i == LAST) ? '0 : i + SELW'(1);
    endfunction

    assign load = !out_valid_q || out_ready;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        win       = '0;
        any_grant = 1'b0;
        for (int off = 0; off < NCH; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!any_grant && in_valid[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                win        = SELW'(idx);
            end
        end
    end

    assign in_ready = rst ? '0 : (grant & {NCH{load}});

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
`ifdef RR_MUX_GRANT_HOLD_EN
        hold_d      = hold_q;
`endif
        if (load) begin
            if (any_grant) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data[int'(win)*W +: W];
                out_sel_d   = win;
`ifdef RR_MUX_GRANT_HOLD_EN
                ptr_d       = win;
                hold_d      = 1'b1;
`else
                ptr_d       = wrap_inc(win);
`endif
            end else begin
                out_valid_d = 1'b0;
`ifdef RR_MUX_GRANT_HOLD_EN
                // Held channel went idle: release its priority.
                if (hold_q && !in_valid[ptr_q]) begin
                    ptr_d  = wrap_inc(ptr_q);
                    hold_d = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifdef RR_MUX_GRANT_HOLD_EN
            hold_q      <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifdef RR_MUX_GRANT_HOLD_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (default build, strict rotation).
// Expected words are queued at drive time and popped when consumed.
module tb_rr_arb_mux;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [127:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int checks;
    int errors;
    exp_t sb[$];

    rr_arb_mux #(.W(32), .NCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.sel  = 2'(ch);
        e.data = 32'hA0 + 32'(ch);
        sb.push_back(e);
    endtask

    // Sample mid-cycle; a word seen with out_ready high is consumed.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_sel", 32'(out_sel), 32'(e.sel));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = 32'hA0 + 32'(i);
        end

        // Reset held two cycles with all channels requesting
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_in_ready2", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(in_ready), 32'b0001);
        push(0);
        tick();

        // Full rotation at full throughput
        for (int i = 1; i <= 4; i++) begin
            chk("rr_grant", 32'(in_ready), 32'(4'b0001 << (i % 4)));
            push(i % 4);
            tick();
        end

        // Drain and reset so the pointer restarts at 0
        in_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Sparse requests
        in_valid = 4'b1010;
        #1;
        chk("sparse_g1", 32'(in_ready), 32'b0010);
        push(1);
        tick();
        chk("sparse_g3", 32'(in_ready), 32'b1000);
        push(3);
        tick();
        chk("sparse_g1b", 32'(in_ready), 32'b0010);
        push(1);
        tick();

        // Backpressure while holding A2
        in_valid = 4'b1111;
        #1;
        chk("bp_grant2", 32'(in_ready), 32'b0100);
        push(2);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", out_data, 32'hA2);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(in_ready), 32'b1000);
        push(3);
        tick();

        // Single word from ch2 then idle
        in_valid = 4'b0100;
        #1;
        chk("idle_grant2", 32'(in_ready), 32'b0100);
        push(2);
        tick();
        in_valid = 4'b0000;
        chk("idle_valid_hi", 32'(out_valid), 32'd1);
        tick();
        chk("idle_valid_lo", 32'(out_valid), 32'd0);
        in_valid = 4'b1111;
        #1;
        chk("idle_ptr3", 32'(in_ready), 32'b1000);
        push(3);
        tick();

        // Channels 0..2 valid: strict rotation 0,1,2
        in_valid = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rot3_grant", 32'(in_ready), 32'(4'b0001 << i));
            push(i);
            tick();
        end
        in_valid = 4'b0000;
        tick();
        tick();
        chk("rot3_idle", 32'(out_valid), 32'd0);

        // Reset with a word held: word dropped, priority back to ch0
        out_ready = 1'b0;
        in_valid  = 4'b0011;
        tick();
        chk("mid_held", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_grant0", 32'(in_ready), 32'b0001);
        push(0);
        tick();
        in_valid = 4'b0000;
        tick();
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
